// File: rtl/axi_rd_burst_sram.sv
// AXI4 read-only burst responder over a word-organised on-chip memory, plus a load port.
// Latency: first R beat LATENCY+1 cycles after AR accept, then one beat per cycle.
// Backpressure: rdata/rresp/rlast hold while rvalid && !rready; AR is accepted only in IDLE.
//
// Ports:
//   clock, reset              : rising-edge clock, asynchronous active-high reset
//   araddr/arlen/arsize/arburst/arvalid/arready : AR channel
//   rvalid/rready/rdata/rresp/rlast             : R channel
//   wen/waddr/wdata           : synchronous word write into the memory (not reset)
//
// Optional feature: define CONFIG_AXI_WRAP_EN to support WRAP bursts (arlen 1/3/7/15,
// word-aligned address); otherwise every WRAP request answers SLVERR.
// With CONFIG_AXI_WRAP_EN, MEM_WORDS must be at least 16.

module axi_rd_burst_sram #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned LATENCY   = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [31:0]                  araddr,
   input  logic                         arvalid,
   output logic                         arready,
   input  logic [7:0]                   arlen,
   input  logic [2:0]                   arsize,
   input  logic [1:0]                   arburst,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [31:0]                  rdata,
   output logic [1:0]                   rresp,
   output logic                         rlast,
   input  logic                         wen,
   input  logic [$clog2(MEM_WORDS)-1:0] waddr,
   input  logic [31:0]                  wdata
);

   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t          state, state_nxt;
   logic [31:0]     mem [MEM_WORDS];
   logic [3:0]      lat_cnt;
   logic [7:0]      beat_cnt;
   logic [7:0]      len;
   logic [1:0]      burst;
   logic [AW-1:0]   idx;        // word index of the beat currently presented
   logic [1:0]      resp_q;

   logic            accept, load_first, load_next;
   logic            in_range, wrap_bad;
   logic [1:0]      err_code, load_resp;
   logic [AW-1:0]   start_idx, next_idx, load_idx;

   // Accept-time decode: range check done on 33 bits so BASE_ADDR near the top of
   // the address space does not overflow.
   always_comb begin
      in_range  = ({1'b0, araddr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, araddr} <  ({1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4));
      start_idx = AW'((araddr - BASE_ADDR) >> 2);
`ifdef CONFIG_AXI_WRAP_EN
      wrap_bad  = !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15)) ||
                  (araddr[1:0] != 2'b00);
`else
      wrap_bad  = 1'b1;
`endif
      if (!in_range)
         err_code = 2'b11;
      else if ((arsize != 3'b010) || (arburst == 2'b11) || ((arburst == 2'b10) && wrap_bad))
         err_code = 2'b10;
      else
         err_code = 2'b00;
   end

   // Next beat index. Only the low bits covered by the wrap length move for WRAP;
   // INCR simply rolls over modulo MEM_WORDS through the index width.
   always_comb begin
      next_idx = idx + 1'b1;
      case (burst)
         2'b00: next_idx = idx;
`ifdef CONFIG_AXI_WRAP_EN
         2'b10: begin
            next_idx = (idx & ~{{(AW-4){1'b0}}, len[3:0]}) |
                       ((idx + 1'b1) & {{(AW-4){1'b0}}, len[3:0]});
         end
`endif
         default: next_idx = idx + 1'b1;
      endcase
   end

   // With LATENCY 0 the first beat is loaded on the accept edge itself, straight
   // from the incoming request rather than the latched copy.
   always_comb begin
      load_idx  = accept ? start_idx : idx;
      load_resp = accept ? err_code  : resp_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      arready    = 1'b0;
      rvalid     = 1'b0;
      accept     = 1'b0;
      load_first = 1'b0;
      load_next  = 1'b0;
      case (state)
         IDLE: begin
            arready = !reset;
            if (arvalid && !reset) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  load_first = 1'b1;
                  state_nxt  = BURST;
               end else begin
                  state_nxt  = WAIT;
               end
            end
         end
         WAIT: begin
            if (lat_cnt == 4'd0) begin
               load_first = 1'b1;
               state_nxt  = BURST;
            end
         end
         BURST: begin
            rvalid = 1'b1;
            if (rready) begin
               if (beat_cnt == len)
                  state_nxt = IDLE;
               else
                  load_next = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      rlast = rvalid && (beat_cnt == len);
   end

   assign rresp = resp_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_cnt  <= 4'd0;
         beat_cnt <= 8'd0;
         len      <= 8'd0;
         burst    <= 2'b00;
         idx      <= '0;
         resp_q   <= 2'b00;
         rdata    <= 32'd0;
      end else begin
         if (accept) begin
            len      <= arlen;
            burst    <= arburst;
            resp_q   <= err_code;
            idx      <= start_idx;
            beat_cnt <= 8'd0;
            lat_cnt  <= 4'(LATENCY - 1);
         end
         if (state == WAIT)
            lat_cnt <= lat_cnt - 1'b1;
         // Memory read sees pre-edge contents, so a same-cycle load-port write
         // to the same word is not visible in this beat.
         if (load_first)
            rdata <= (load_resp == 2'b00) ? mem[load_idx] : 32'd0;
         if (load_next) begin
            beat_cnt <= beat_cnt + 1'b1;
            idx      <= next_idx;
            rdata    <= (resp_q == 2'b00) ? mem[next_idx] : 32'd0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wen)
         mem[waddr] <= wdata;
   end

endmodule

// File: tb/tb_axi_rd_burst_sram.sv
// Self-checking bench for axi_rd_burst_sram: table of bursts driven through a
// scoreboard of expected beats, plus hand sequences for load collision and reset.
module tb_axi_rd_burst_sram;

   localparam int          MEM_WORDS = 1024;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          LAT       = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        wen;
   logic [9:0]  waddr;
   logic [31:0] wdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [MEM_WORDS];

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;
   beat_t exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  rpat;
   } vec_t;
   vec_t vecs[10];

   axi_rd_burst_sram #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .wen(wen), .waddr(waddr), .wdata(wdata)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: derives every beat from byte-address arithmetic.
   task automatic push_expected(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
      longint unsigned a   = longint'(addr);
      longint unsigned lo  = longint'(BASE);
      longint unsigned hi  = lo + 4 * MEM_WORDS;
      longint unsigned off, ba, blk;
      logic [1:0] resp;
      bit wrap_ok;
      beat_t b;
`ifdef CONFIG_AXI_WRAP_EN
      wrap_ok = (len == 1 || len == 3 || len == 7 || len == 15) && (addr[1:0] == 2'b00);
`else
      wrap_ok = 1'b0;
`endif
      if (a < lo || a >= hi)                                        resp = 2'b11;
      else if (size != 3'b010 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) resp = 2'b10;
      else                                                          resp = 2'b00;
      off = a - lo;
      blk = 4 * (longint'(len) + 1);
      for (int i = 0; i <= int'(len); i++) begin
         case (burst)
            2'b00:   ba = off;
            2'b10:   ba = (off / blk) * blk + ((off % blk) + 4 * i) % blk;
            default: ba = off + 4 * i;
         endcase
         b.resp = resp;
         b.data = (resp == 2'b00) ? ref_mem[(ba / 4) % MEM_WORDS] : 32'd0;
         b.last = (i == int'(len));
         exp_q.push_back(b);
      end
   endtask

   task automatic issue(input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      @(negedge clock);
      chk("arready_idle", {31'd0, arready}, 32'd1);
      araddr  = addr;
      arlen   = len;
      arsize  = size;
      arburst = burst;
      arvalid = 1'b1;
      @(posedge clock);
      #1 arvalid = 1'b0;
   endtask

   // Runs one burst already issued. Cycle k=1 is the first negedge after accept.
   task automatic run_burst(input logic [3:0] rpat, input int nbeats, input int collide_k);
      int  k = 0;
      int  hs = 0;
      int  first = -1;
      beat_t e;
      while (hs < nbeats && k < 2000) begin
         @(negedge clock);
         k++;
         rready = rpat[k % 4];
         wen    = (k == collide_k);
         waddr  = 10'd0;
         wdata  = 32'h1234_5678;
         if (rvalid) begin
            if (first < 0) begin
               first = k;
               chk("first_beat_latency", 32'(k), 32'(LAT + 1));
            end
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
               k = 2000;
            end else begin
               e = exp_q[0];
               chk("rdata", rdata, e.data);
               chk("rresp", {30'd0, rresp}, {30'd0, e.resp});
               chk("rlast", {31'd0, rlast}, {31'd0, e.last});
               if (rready) begin
                  void'(exp_q.pop_front());
                  hs++;
               end
            end
         end else if (first < 0 && k <= LAT) begin
            chk("arready_wait", {31'd0, arready}, 32'd0);
         end
      end
      wen = 1'b0;
      if (k >= 2000) chk("burst_timeout", 32'(k), 32'd0);
      chk("handshakes", 32'(hs), 32'(nbeats));
      @(negedge clock);
      rready = 1'b0;
      chk("arready_after", {31'd0, arready}, 32'd1);
      chk("rvalid_after", {31'd0, rvalid}, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int hs;
      int k;
      beat_t b;

      vecs[0] = '{32'h8000_0010, 8'd3,   3'b010, 2'b01, 4'b1111}; // INCR
      vecs[1] = '{32'h8000_0010, 8'd3,   3'b010, 2'b01, 4'b1001}; // backpressure
      vecs[2] = '{32'h8000_0000, 8'd1,   3'b011, 2'b01, 4'b1111}; // bad size
      vecs[3] = '{32'h7FFF_FFF0, 8'd3,   3'b010, 2'b01, 4'b0110}; // below range
      vecs[4] = '{32'h8000_0008, 8'd3,   3'b010, 2'b10, 4'b1111}; // WRAP
      vecs[5] = '{32'h8000_0FFC, 8'd3,   3'b010, 2'b01, 4'b1101}; // index rollover
      vecs[6] = '{32'h8000_0040, 8'd0,   3'b010, 2'b11, 4'b1111}; // reserved burst
      vecs[7] = '{32'h8000_1000, 8'd0,   3'b010, 2'b01, 4'b1111}; // just past top
      vecs[8] = '{32'h8000_0000, 8'd255, 3'b010, 2'b01, 4'b1111}; // 256 beats
      vecs[9] = '{32'h8000_0020, 8'd2,   3'b010, 2'b10, 4'b1111}; // illegal wrap len

      reset = 1'b1; arvalid = 1'b0; araddr = '0; arlen = '0; arsize = 3'b010;
      arburst = 2'b01; rready = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;

      #12;
      chk("reset_rvalid",  {31'd0, rvalid},  32'd0);
      chk("reset_rlast",   {31'd0, rlast},   32'd0);
      chk("reset_rresp",   {30'd0, rresp},   32'd0);
      chk("reset_rdata",   rdata,            32'd0);
      chk("reset_arready", {31'd0, arready}, 32'd0);

      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         wen = 1'b1; waddr = 10'(i); wdata = 32'hA000_0000 + i;
         ref_mem[i] = 32'hA000_0000 + i;
         @(negedge clock);
      end
      wen = 1'b0;

      for (int v = 0; v < 10; v++) begin
         issue(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
         push_expected(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
         run_burst(vecs[v].rpat, int'(vecs[v].len) + 1, 0);
      end

      // FIXED burst with a load-port write to word 0 on the first beat-load edge.
      issue(32'h8000_0000, 8'd2, 3'b010, 2'b00);
      b.resp = 2'b00;
      b.data = 32'hA000_0000; b.last = 1'b0; exp_q.push_back(b);
      b.data = 32'h1234_5678; b.last = 1'b0; exp_q.push_back(b);
      b.data = 32'h1234_5678; b.last = 1'b1; exp_q.push_back(b);
      run_burst(4'b1111, 3, LAT);
      ref_mem[0] = 32'h1234_5678;

      // Reset during the second beat of a 4-beat INCR.
      issue(32'h8000_0010, 8'd3, 3'b010, 2'b01);
      rready = 1'b1;
      hs = 0;
      k  = 0;
      while (k < 50) begin
         @(negedge clock);
         k++;
         if (rvalid) begin
            if (hs == 1) break;
            hs++;
         end
      end
      chk("reset_test_reached_beat2", 32'(k < 50), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midreset_rvalid",  {31'd0, rvalid},  32'd0);
      chk("midreset_rlast",   {31'd0, rlast},   32'd0);
      chk("midreset_rdata",   rdata,            32'd0);
      chk("midreset_rresp",   {30'd0, rresp},   32'd0);
      chk("midreset_arready", {31'd0, arready}, 32'd0);
      exp_q.delete();
      rready = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // New burst after reset, plus a FIXED read of word 0 to show memory retained.
      issue(32'h8000_0010, 8'd3, 3'b010, 2'b01);
      push_expected(32'h8000_0010, 8'd3, 3'b010, 2'b01);
      run_burst(4'b1111, 4, 0);
      issue(32'h8000_0000, 8'd0, 3'b010, 2'b00);
      push_expected(32'h8000_0000, 8'd0, 3'b010, 2'b00);
      run_burst(4'b1111, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
